// File: rtl/hwpe_stream_seq_pkg.sv
// hwpe_stream_seq_pkg
// Shared types and helpers for hwpe_stream_demux_sequencer.
//   DEFAULT_BURST_LEN : default beats per destination
//   SEQ_CNT_W/PTR_W   : storage widths of the rotation state
//                       (BURST_LEN <= 2**16, NB_OUT_STREAMS <= 128)
//   seq_state_t       : rotation state {beat_cnt, dest_ptr}
//   next_dest()       : round-robin wrap rule for the destination pointer
package hwpe_stream_seq_pkg;

    localparam int DEFAULT_BURST_LEN = 4;
    localparam int SEQ_CNT_W         = 16;
    localparam int SEQ_PTR_W         = 8;

    typedef struct packed {
        logic [SEQ_CNT_W-1:0] beat_cnt;
        logic [SEQ_PTR_W-1:0] dest_ptr;
    } seq_state_t;

    // Advance to ptr+1, wrapping to 0 once the active set is exhausted. The
    // ">=" (not "==") also pulls the pointer home when the active set has
    // shrunk below the current pointer.
    function automatic logic [SEQ_PTR_W-1:0] next_dest(
        input logic [SEQ_PTR_W-1:0] ptr,
        input logic [SEQ_PTR_W-1:0] eff_active
    );
        logic [SEQ_PTR_W:0] w_inc;
        w_inc = {1'b0, ptr} + {{SEQ_PTR_W{1'b0}}, 1'b1};
        if (w_inc >= {1'b0, eff_active})
            return '0;
        return w_inc[SEQ_PTR_W-1:0];
    endfunction

endpackage

// File: rtl/hwpe_stream_seq_reg_slice.sv
// hwpe_stream_seq_reg_slice
// Single-entry register slice carrying {data, strb, sel} with valid/ready.
//   clk_i, rst_i (sync, active-high), clear_i (sync soft clear)
//   in_*  : upstream beat plus the destination tag to attach to it
//   out_* : registered beat; held stable while out_valid_o && !out_ready_i
module hwpe_stream_seq_reg_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int SEL_WIDTH  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [STRB_WIDTH-1:0] in_strb_i,
    input  logic [SEL_WIDTH-1:0]  in_sel_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [STRB_WIDTH-1:0] out_strb_o,
    output logic [SEL_WIDTH-1:0]  out_sel_o
);

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic [STRB_WIDTH-1:0] r_strb;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic                  w_accept;

    // Ready depends only on occupancy and downstream ready, never on in_valid_i.
    assign in_ready_o = !rst_i && !clear_i && (!r_full || out_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_strb <= '0;
            r_sel  <= '0;
        end else if (clear_i) begin
            // Payload is kept so sel/data do not glitch while invalid.
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_data <= in_data_i;
            r_strb <= in_strb_i;
            r_sel  <= in_sel_i;
        end else if (out_ready_i) begin
            r_full <= 1'b0;
        end
    end

    assign out_valid_o = r_full;
    assign out_data_o  = r_data;
    assign out_strb_o  = r_strb;
    assign out_sel_o   = r_sel;

endmodule

// File: rtl/hwpe_stream_demux_sequencer.sv
// hwpe_stream_demux_sequencer
// Registers one HWPE stream and tags each beat with a round-robin destination
// select for a downstream static demux; the destination advances every
// BURST_LEN accepted beats over the first eff_active outputs.
//   clk_i, rst_i (sync, active-high), clear_i (sync soft clear)
//   nb_active_i : active destination count (0 -> 1, > NB_OUT_STREAMS clamped)
//   push_*      : input stream (valid, ready, data, strb)
//   pop_*       : registered output stream
//   sel_o       : destination of the beat on pop_*
// Optional (HWPE_STREAM_DEMUX_SEQUENCER_STATS_EN):
//   stat_beats_o : saturating count of pop handshakes
//   stat_stall_o : saturating count of valid && !ready cycles
module hwpe_stream_demux_sequencer
    import hwpe_stream_seq_pkg::*;
#(
    parameter  int NB_OUT_STREAMS = 2,
    parameter  int DATA_WIDTH     = 32,
    parameter  int BURST_LEN      = DEFAULT_BURST_LEN,
    localparam int STRB_WIDTH     = DATA_WIDTH/8,
    localparam int SEL_WIDTH      = (NB_OUT_STREAMS > 1) ? $clog2(NB_OUT_STREAMS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [SEL_WIDTH:0]    nb_active_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic [STRB_WIDTH-1:0] push_strb_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic [STRB_WIDTH-1:0] pop_strb_o,
    output logic [SEL_WIDTH-1:0]  sel_o
`ifdef HWPE_STREAM_DEMUX_SEQUENCER_STATS_EN
    ,
    output logic [31:0]           stat_beats_o,
    output logic [31:0]           stat_stall_o
`endif
);

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic [SEQ_PTR_W-1:0] w_eff_active;
    logic                 w_accept;

    always_comb begin
        w_eff_active = SEQ_PTR_W'(nb_active_i);
        if (nb_active_i == '0)
            w_eff_active = SEQ_PTR_W'(1);
        else if (nb_active_i > (SEL_WIDTH+1)'(NB_OUT_STREAMS))
            w_eff_active = SEQ_PTR_W'(NB_OUT_STREAMS);
    end

    assign w_accept = push_valid_i && push_ready_o;

    // Rotation follows accepts, so tags are fixed at entry and an active-set
    // change only takes effect at the next burst boundary.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (r_state.beat_cnt == SEQ_CNT_W'(BURST_LEN-1)) begin
                w_state_nxt.beat_cnt = '0;
                w_state_nxt.dest_ptr = next_dest(r_state.dest_ptr, w_eff_active);
            end else begin
                w_state_nxt.beat_cnt = r_state.beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i)
            r_state <= '0;
        else
            r_state <= w_state_nxt;
    end

    hwpe_stream_seq_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) i_slice (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .in_valid_i  (push_valid_i),
        .in_ready_o  (push_ready_o),
        .in_data_i   (push_data_i),
        .in_strb_i   (push_strb_i),
        .in_sel_i    (r_state.dest_ptr[SEL_WIDTH-1:0]),
        .out_valid_o (pop_valid_o),
        .out_ready_i (pop_ready_i),
        .out_data_o  (pop_data_o),
        .out_strb_o  (pop_strb_o),
        .out_sel_o   (sel_o)
    );

`ifdef HWPE_STREAM_DEMUX_SEQUENCER_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_stat_beats <= '0;
            r_stat_stall <= '0;
        end else begin
            if (pop_valid_o && pop_ready_i && (r_stat_beats != '1))
                r_stat_beats <= r_stat_beats + 1'b1;
            if (pop_valid_o && !pop_ready_i && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_beats_o = r_stat_beats;
    assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_hwpe_stream_demux_sequencer.sv
module tb_hwpe_stream_demux_sequencer;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int BL = 3;

    logic          clk = 1'b0;
    logic          rst, clear;
    logic [SW:0]   nb_active;
    logic          push_valid, push_ready, pop_valid, pop_ready;
    logic [DW-1:0] push_data, pop_data;
    logic [3:0]    push_strb, pop_strb;
    logic [SW-1:0] sel;
`ifdef HWPE_STREAM_DEMUX_SEQUENCER_STATS_EN
    logic [31:0]   stat_beats, stat_stall;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    strb;
        logic [SW-1:0] sel;
    } beat_t;

    beat_t sb_q[$];
    int    n_chk = 0, n_fail = 0;
    int    m_cnt = 0, m_ptr = 0;     // reference rotation: beats into burst, current destination
    int    m_beats = 0, m_stall = 0; // reference statistics
    bit    mon_en = 1'b0;

    always #5 clk = ~clk;

    hwpe_stream_demux_sequencer #(
        .NB_OUT_STREAMS (NB),
        .DATA_WIDTH     (DW),
        .BURST_LEN      (BL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .nb_active_i  (nb_active),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready),
        .push_data_i  (push_data),
        .push_strb_i  (push_strb),
        .pop_valid_o  (pop_valid),
        .pop_ready_i  (pop_ready),
        .pop_data_o   (pop_data),
        .pop_strb_o   (pop_strb),
        .sel_o        (sel)
`ifdef HWPE_STREAM_DEMUX_SEQUENCER_STATS_EN
        ,
        .stat_beats_o (stat_beats),
        .stat_stall_o (stat_stall)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input int nb);
        if (nb == 0) return 1;
        if (nb > NB) return NB;
        return nb;
    endfunction

    // One cycle of stimulus; expected beats enter the scoreboard on accept.
    task automatic step(input bit pv, input logic [DW-1:0] d, input logic [3:0] s,
                        input bit pr, input bit clr);
        bit    acc;
        beat_t b;
        push_valid = pv; push_data = d; push_strb = s; pop_ready = pr; clear = clr;
        @(negedge clk);
        chk("push_ready", push_ready, !clr && (sb_q.size() == 0 || pr));
        acc = pv && push_ready;
        b   = '0;
        if (acc) begin
            b.data = d;
            b.strb = s;
            b.sel  = SW'(m_ptr);
            m_cnt++;
            if (m_cnt == BL) begin
                m_cnt = 0;
                m_ptr = (m_ptr + 1 >= eff(int'(nb_active))) ? 0 : m_ptr + 1;
            end
        end
        @(posedge clk);
        if (clr) begin
            sb_q.delete();
            m_cnt = 0; m_ptr = 0; m_beats = 0; m_stall = 0;
        end
        if (acc) sb_q.push_back(b);
        #1;
    endtask

    // Monitor: whatever is on pop_* must be the oldest outstanding beat.
    always @(negedge clk) begin
        if (mon_en) begin
`ifdef HWPE_STREAM_DEMUX_SEQUENCER_STATS_EN
            chk("stat_beats", stat_beats, m_beats);
            chk("stat_stall", stat_stall, m_stall);
`endif
            chk("pop_valid", pop_valid, sb_q.size() != 0);
            if (pop_valid && sb_q.size() != 0) begin
                chk("pop_data", pop_data, sb_q[0].data);
                chk("pop_strb", pop_strb, sb_q[0].strb);
                chk("sel",      sel,      sb_q[0].sel);
                if (pop_ready) begin
                    void'(sb_q.pop_front());
                    m_beats++;
                end
            end
            if (pop_valid && !pop_ready) m_stall++;
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; nb_active = 3'd2;
        push_valid = 1'b0; push_data = '0; push_strb = '0; pop_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", pop_valid, 0);
        chk("rst_data",  pop_data,  0);
        chk("rst_strb",  pop_strb,  0);
        chk("rst_sel",   sel,       0);
        chk("rst_ready", push_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Steady flow, two active destinations.
        for (int i = 0; i < 12; i++) step(1'b1, DW'(i), 4'hF, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure with one beat held.
        step(1'b1, 32'hA5, 4'h3, 1'b1, 1'b0);
        repeat (3) step(1'b1, $urandom, 4'hF, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Active set shrinks while on destination 3, mid-burst.
        step(1'b0, '0, '0, 1'b1, 1'b1);
        nb_active = 3'd4;
        for (int i = 0; i < 3*BL + 1; i++) step(1'b1, DW'(100 + i), 4'h1, 1'b1, 1'b0);
        nb_active = 3'd2;
        for (int i = 0; i < BL + 2; i++) step(1'b1, DW'(200 + i), 4'h2, 1'b1, 1'b0);

        // Partial set of 3, then zero (treated as 1) and over-range (clamped).
        step(1'b0, '0, '0, 1'b1, 1'b1);
        nb_active = 3'd3;
        for (int i = 0; i < 4*BL; i++) step(1'b1, DW'(i), 4'h4, 1'b1, 1'b0);
        nb_active = 3'd0;
        for (int i = 0; i < 3*BL; i++) step(1'b1, DW'(i), 4'h5, 1'b1, 1'b0);
        nb_active = 3'd7;
        for (int i = 0; i < 5*BL; i++) step(1'b1, DW'(i), 4'h6, 1'b1, 1'b0);

        // Clear mid-burst with a beat registered and downstream stalled.
        step(1'b1, 32'h11, 4'hF, 1'b1, 1'b0);
        step(1'b1, 32'h22, 4'hF, 1'b0, 1'b0);
        step(1'b1, 32'h33, 4'hF, 1'b0, 1'b1);
        for (int i = 0; i < BL + 1; i++) step(1'b1, DW'(300 + i), 4'h7, 1'b1, 1'b0);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) nb_active = SW'(0) + 3'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, $urandom, 4'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("sb_empty", sb_q.size(), 0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_demux_sequencer.md
Name: hwpe_stream_demux_sequencer

Overview:
- Upstream companion of the static HWPE stream demux.
- Registers one incoming HWPE stream and emits it with a per-beat destination select (sel_o) aligned to each output beat.
- Destinations rotate round-robin over nb_active_i outputs, switching every BURST_LEN handshaked beats.
- pop_o and sel_o drive the demux push_i and sel_i directly.

Parameters:
- NB_OUT_STREAMS, 2, number of demux outputs to rotate over (>=1).
- DATA_WIDTH, 32, stream data width; STRB_WIDTH = DATA_WIDTH/8.
- BURST_LEN, 4, handshaked beats sent to one destination before advancing (>=1).
- SEL_WIDTH, max(1,$clog2(NB_OUT_STREAMS)), width of select (localparam).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-high
- clear_i  input  1  synchronous soft clear
- nb_active_i  input  SEL_WIDTH+1  number of active destinations; 0 treated as 1, values >NB_OUT_STREAMS clamped
- push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  input stream (valid, ready, data, strb)
- pop_o  hwpe_stream_intf_stream.source  DATA_WIDTH  registered output stream
- sel_o  output  SEL_WIDTH  destination of the beat currently on pop_o

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Storage: single-entry pipeline register {data, strb, sel, full}.
- Reset values: pop_o.valid=0, pop_o.data=0, pop_o.strb=0, sel_o=0, full=0, beat_cnt=0, dest_ptr=0.
- push_i.ready = !full || pop_o.ready. Combinational from pop_o.ready only; no path from push_i.valid.
- Accept (push_i.valid && push_i.ready):
  - Register loads data/strb and sel=dest_ptr; full=1 next cycle.
  - Latency 1 cycle; full throughput (1 beat/cycle) when pop_o.ready stays high.
- Drain (pop_o.valid && pop_o.ready) without accept: full=0.
- Drain and accept in the same cycle: register reloads, full stays 1.
- pop_o.valid = full. While valid && !ready, data, strb and sel_o stay stable (AXI-style hold).
- Rotation counters advance on accept, not on drain:
  - beat_cnt increments on each accept.
  - When beat_cnt == BURST_LEN-1 on an accept: beat_cnt <= 0 and dest_ptr advances.
  - Advance wraps: dest_ptr <= (dest_ptr+1 >= eff_active) ? 0 : dest_ptr+1, where eff_active = clamped nb_active_i.
- BURST_LEN=1: dest_ptr advances on every accept.
- eff_active=1 or NB_OUT_STREAMS=1: dest_ptr stays 0.
- nb_active_i changed mid-burst: current burst completes. If dest_ptr >= new eff_active, the next advance goes to 0. Beats already registered keep their tagged sel.
- clear_i (and rst_i):
  - Drops the registered beat (full=0); beat_cnt=0, dest_ptr=0.
  - push_i.ready=0 in the clear cycle.
  - rst_i has priority over clear_i.
- sel_o is don't-care when pop_o.valid=0 but is held at its last value (no glitching).

Optional Feature:
- Macro: HWPE_STREAM_DEMUX_SEQUENCER_STATS_EN
- Defined:
  - Adds output stat_beats_o [31:0]: count of drains (pop handshakes), saturating at 32'hFFFF_FFFF.
  - Adds output stat_stall_o [31:0]: cycles with pop_o.valid && !pop_o.ready, saturating.
  - Both reset to 0 on rst_i or clear_i.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package hwpe_stream_seq_pkg:
  - DEFAULT_BURST_LEN.
  - Typedef seq_state_t {beat_cnt, dest_ptr}.
  - Function next_dest(ptr, eff_active) implementing the wrap rule.
- Sub-module hwpe_stream_seq_reg_slice: the single-entry data/strb/sel register with valid/ready logic.
- Top module holds counters, clamping and the optional stats.

Test Plan:
- Steady flow: NB_OUT=2, BURST_LEN=4, nb_active=2, push valid every cycle, pop_o.ready=1, data 0..11 -> first pop cycle 1 after first push; sel_o sequence 0,0,0,0,1,1,1,1,0,0,0,0; data in order.
- Backpressure: pop_o.ready=0 for 3 cycles with beat 0xA5 registered -> data/strb/sel_o stable; push_i.ready=0; no beat lost or duplicated after ready returns.
- Partial active set: NB_OUT=4, BURST_LEN=1, nb_active=3 -> sel_o 0,1,2,0,1,2; nb_active=0 -> sel_o constantly 0.
- Mid-burst change: NB_OUT=4, BURST_LEN=2, nb_active 4->2 while dest_ptr=3 after one beat -> second beat sel=3, next burst sel=0.
- Clear mid-burst: clear_i after 2 of 4 beats with full=1 -> pop_o.valid=0 next cycle; next accepted beat tagged sel=0; new burst of 4.
- Stats (macro defined): 10 drains, 5 stall cycles -> stat_beats_o=10, stat_stall_o=5; both 0 after clear_i.
